mic_frame_sched: RTL
====================

// Module: mic_frame_sched
// PURPOSE
//  Read-side controller for the 128-entry mic sample FIFO. Counts FIFO occupancy
//  by watching FIFO write and read events. Once a full frame of FRAME_LEN samples
//  is buffered, it drains exactly FRAME_LEN samples in one burst. Each sample goes
//  to the feature-extraction path over a valid/ready stream, with end-of-frame
//  marking and sticky overflow/underrun flags.
// PARAMETERS
//  DATA_W     16   sample width; matches the FIFO data width
//  FRAME_LEN  64   samples per frame; legal range 1..127
//  OCC_W      8    occupancy counter width; must hold 0..127
// PORTS
//  clk           in   1       system clock; all logic on rising edge
//  rst           in   1       asynchronous, active-low reset
//  en            in   1       frame scheduling enable
//  clr_flags     in   1       synchronous clear of overflow/underrun
//  fifo_wr_en    in   1       copy of the wr_en driven into the FIFO
//  fifo_full     in   1       FIFO full flag
//  fifo_empty    in   1       FIFO empty flag
//  fifo_dout     in   DATA_W  FIFO registered read data
//  fifo_rd_en    out  1       FIFO read strobe
//  m_data        out  DATA_W  output sample
//  m_valid       out  1       m_data valid
//  m_ready       in   1       downstream accept
//  m_last        out  1       m_valid on the final sample of a frame
//  occ           out  OCC_W   tracked FIFO occupancy
//  frame_cnt     out  16      completed frames; wraps at 2^16
//  overflow      out  1       sticky: write attempted while full
//  underrun      out  1       sticky: read issued while empty
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; occ, idx, frame_cnt, m_data = 0.
//   fifo_rd_en, m_valid, m_last, overflow, underrun = 0.
//   The FIFO shares rst, so occ=0 stays consistent with it.
//  occ: +1 on (fifo_wr_en & !fifo_full); -1 on (fifo_rd_en & !fifo_empty).
//   Both in the same cycle: occ is unchanged. Maximum value is 127; FIFO full is wr+1==rd.
//  FSM states: IDLE, WAIT_FILL, ISSUE, LATCH, SEND. idx = sample index 0..FRAME_LEN-1.
//   IDLE:      en=1 -> WAIT_FILL.
//   WAIT_FILL: en=0 -> IDLE.
//              Else if occ >= FRAME_LEN -> ISSUE, idx=0.
//              The comparison uses the registered occ.
//   ISSUE:     fifo_rd_en=1 for exactly this cycle -> LATCH.
//              If fifo_empty=1 here, set underrun; the sequence still proceeds.
//   LATCH:     FIFO dout updates at this edge.
//              m_data <= fifo_dout at the end of LATCH -> SEND.
//   SEND:      m_valid=1; m_last=(idx==FRAME_LEN-1).
//              m_data is held stable until m_ready=1.
//              On m_valid & m_ready:
//                if idx < FRAME_LEN-1: idx++, -> ISSUE.
//                else: frame_cnt++, -> WAIT_FILL if en, else IDLE.
//  en deasserted mid-frame: the frame always completes. en is sampled only in
//   IDLE, WAIT_FILL and at frame end.
//  fifo_rd_en, m_valid and m_last decode from state only. No combinational path
//   from m_ready to fifo_rd_en.
//  Throughput: 3 cycles/sample with m_ready held at 1. A frame takes 3*FRAME_LEN cycles.
//   Latency from occ reaching FRAME_LEN to the first m_valid is 3 cycles.
//  overflow: set on fifo_wr_en & fifo_full.
//  underrun: set as described in ISSUE.
//  Flag clear: clr_flags=1 clears both flags next edge. If set and clr_flags
//   occur in the same cycle, set wins.
//  m_ready low in SEND: the FSM stalls with no FIFO reads, while occ keeps counting writes.
// TESTING
//  1 Reset: hold rst=0, then release -> all outputs 0, state IDLE, occ=0.
//  2 Basic frame (FRAME_LEN=64): en=1, write 64 samples 0..63, m_ready=1.
//    -> 64 beats 0..63; m_last only on value 63; frame_cnt=1; occ=0; 192 cycles.
//  3 Backpressure: toggle m_ready every 5 cycles during a frame.
//    -> no sample lost or duplicated; m_data stable while m_valid & !m_ready.
//  4 Concurrent write/read: keep writing 1 sample/2 cycles during a frame.
//    -> occ correct every cycle; second frame starts when occ>=64.
//  5 Overflow: en=0, write 130 samples -> occ=127, overflow=1.
//    Then clr_flags=1 -> overflow=0.
//  6 Mid-operation: drop en mid-frame -> frame completes, then IDLE.
//    Assert rst mid-frame -> outputs 0 immediately (async), occ=0.

Source files
------------

// File: rtl/mic_frame_sched.sv
// Read-side scheduler for the mic sample FIFO: tracks occupancy and drains one
// full frame per burst onto a valid/ready stream with end-of-frame marking.
module mic_frame_sched #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 64,
  parameter int OCC_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr_flags,
  input  logic              fifo_wr_en,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [OCC_W-1:0]  occ,
  output logic [15:0]       frame_cnt,
  output logic              overflow,
  output logic              underrun
);

  typedef enum logic [2:0] {IDLE, WAIT_FILL, ISSUE, LATCH, SEND} state_t;

  localparam logic [OCC_W-1:0] LAST_IDX  = OCC_W'(FRAME_LEN - 1);
  localparam logic [OCC_W-1:0] FRAME_OCC = OCC_W'(FRAME_LEN);

  state_t           state, state_nxt;
  logic [OCC_W-1:0] idx, idx_nxt;
  logic             wr_ok, rd_ok, beat, is_last;

  assign wr_ok   = fifo_wr_en & ~fifo_full;
  assign rd_ok   = fifo_rd_en & ~fifo_empty;
  assign is_last = (idx == LAST_IDX);
  assign beat    = m_valid & m_ready;

  // Strobes decode from state alone so m_ready never reaches fifo_rd_en.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    fifo_rd_en = 1'b0;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    case (state)
      IDLE: if (en) state_nxt = WAIT_FILL;
      WAIT_FILL: begin
        if (!en) state_nxt = IDLE;
        else if (occ >= FRAME_OCC) begin
          state_nxt = ISSUE;
          idx_nxt   = '0;
        end
      end
      ISSUE: begin
        fifo_rd_en = 1'b1;
        state_nxt  = LATCH;
      end
      LATCH: state_nxt = SEND;
      SEND: begin
        m_valid = 1'b1;
        m_last  = is_last;
        if (beat) begin
          if (is_last) state_nxt = en ? WAIT_FILL : IDLE;
          else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      occ       <= '0;
      frame_cnt <= '0;
      m_data    <= '0;
      overflow  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      case ({wr_ok, rd_ok})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      // FIFO read data is registered, so it is valid during LATCH.
      if (state == LATCH) m_data <= fifo_dout;
      if (beat && is_last) frame_cnt <= frame_cnt + 1'b1;
      if (fifo_wr_en && fifo_full) overflow <= 1'b1;
      else if (clr_flags)          overflow <= 1'b0;
      if (fifo_rd_en && fifo_empty) underrun <= 1'b1;
      else if (clr_flags)           underrun <= 1'b0;
    end
  end

endmodule
